// File: rtl/wt_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// wt_bin2bcd_seq
//   Sequential binary-to-BCD converter for the watch datapath. One input bit
//   is consumed per clock by a shift-add-3 engine. START/BUSY/DONE handshake.
//   Values above 10^DIGITS-1 raise OVF and return either all zeros or all
//   nines, chosen by SAT_MODE.
//
// Parameters
//   IN_W     input width in bits (1..32)
//   DIGITS   number of BCD digits (1..10)
//   SAT_MODE out-of-range result: 0 = all digits 0, 1 = all digits 9
//
// Ports
//   CLK     rising-edge clock
//   RESET   asynchronous reset, active-high
//   START   conversion request, sampled only while idle
//   NUMBER  unsigned binary value, captured on the accepting edge
//   BCD     packed result, digit 0 (units) in [3:0]
//   BUSY    conversion in progress
//   DONE    one-cycle pulse, BCD/OVF updated this cycle
//   OVF     last result was out of range
// -----------------------------------------------------------------------------
module wt_bin2bcd_seq #(
  parameter int IN_W     = 7,
  parameter int DIGITS   = 2,
  parameter int SAT_MODE = 0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [IN_W-1:0]       NUMBER,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  OVF
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  function automatic logic [63:0] pow10_minus1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  // Largest representable value and largest possible input, both elaborated.
  localparam logic [63:0] LIMIT        = pow10_minus1(DIGITS);
  localparam logic [63:0] IN_MAX       = (64'd1 << IN_W) - 64'd1;
  localparam bit          OVF_POSSIBLE = (LIMIT < IN_MAX);
  localparam logic [BCD_W-1:0] SAT_VALUE = (SAT_MODE != 0) ? {DIGITS{4'h9}} : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FINISH
  } state_e;

  // Add 3 to every digit >= 5 so the following left shift carries correctly
  // into the next decimal digit. Each digit wraps in 4 bits.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int k = 0; k < DIGITS; k++) begin
      if (s[4*k +: 4] >= 4'd5) r[4*k +: 4] = s[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  state_e              state_q,   state_d;
  logic [BCD_W-1:0]    scratch_q, scratch_d;
  logic [IN_W-1:0]     bin_q,     bin_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]    bcd_q,     bcd_d;
  logic                ovf_q,     ovf_d;
  logic                done_q,    done_d;
  logic                busy_q,    busy_d;

  logic [BCD_W-1:0]    adj;
  logic                ovf_in;

  assign adj = add3(scratch_q);

  // Range check happens on the raw input and is latched with the capture, so
  // the shifted-out binary register never needs to be kept.
  always_comb begin
    ovf_in = 1'b0;
    if (OVF_POSSIBLE) ovf_in = (64'(NUMBER) > LIMIT);
  end

  // NOTE: every combinational output takes its default before the case so no
  // path leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    state_d    = state_q;
    scratch_d  = scratch_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          bin_d      = NUMBER;
          scratch_d  = '0;
          cnt_d      = CNT_W'(IN_W);
          ovf_pend_d = ovf_in;
          busy_d     = 1'b1;
          state_d    = S_SHIFT;
        end
      end

      S_SHIFT: begin
        {scratch_d, bin_d} = {adj, bin_q} << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FINISH;
      end

      S_FINISH: begin
        ovf_d   = ovf_pend_q;
        bcd_d   = ovf_pend_q ? SAT_VALUE : scratch_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      scratch_q  <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scratch_q  <= scratch_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign BCD  = bcd_q;
  assign OVF  = ovf_q;
  assign DONE = done_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_wt_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_wt_bin2bcd_seq
//   Three instances: defaults with SAT_MODE=0 (a0) and SAT_MODE=1 (a1) share
//   one stimulus stream; a 17-bit/5-digit instance (b) has its own. Drivers
//   push expected results into per-instance queues; monitors pop and compare
//   on every DONE, including latency from the capture edge.
// -----------------------------------------------------------------------------
module tb_wt_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stream A: IN_W=7, DIGITS=2
  logic       start_a = 1'b0;
  logic [6:0] num_a   = '0;
  logic [7:0] bcd_a0, bcd_a1;
  logic       busy_a0, done_a0, ovf_a0;
  logic       busy_a1, done_a1, ovf_a1;

  // Stream B: IN_W=17, DIGITS=5
  logic        start_b = 1'b0;
  logic [16:0] num_b   = '0;
  logic [19:0] bcd_b;
  logic        busy_b, done_b, ovf_b;

  wt_bin2bcd_seq #(.IN_W(7), .DIGITS(2), .SAT_MODE(0)) u_a0 (
    .CLK(clk), .RESET(rst), .START(start_a), .NUMBER(num_a),
    .BCD(bcd_a0), .BUSY(busy_a0), .DONE(done_a0), .OVF(ovf_a0));

  wt_bin2bcd_seq #(.IN_W(7), .DIGITS(2), .SAT_MODE(1)) u_a1 (
    .CLK(clk), .RESET(rst), .START(start_a), .NUMBER(num_a),
    .BCD(bcd_a1), .BUSY(busy_a1), .DONE(done_a1), .OVF(ovf_a1));

  wt_bin2bcd_seq #(.IN_W(17), .DIGITS(5), .SAT_MODE(0)) u_b (
    .CLK(clk), .RESET(rst), .START(start_b), .NUMBER(num_b),
    .BCD(bcd_b), .BUSY(busy_b), .DONE(done_b), .OVF(ovf_b));

  typedef struct {
    logic [19:0] bcd;
    logic        ovf;
    int          cap;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int errors = 0;
  int checks = 0;

  bit sweep_on = 1'b0;
  int last_a0  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DONE with no pending conversion (t=%0t)", name, $time);
  endtask

  // ---------------------------------------------------------------- monitors
  always @(negedge clk) begin : mon_a0
    exp_t e;
    if (!rst && done_a0) begin
      if (q0.size() == 0) unexpected("a0 extra DONE");
      else begin
        e = q0.pop_front();
        check("a0 bcd", 64'(bcd_a0), 64'(e.bcd));
        check("a0 ovf", 64'(ovf_a0), 64'(e.ovf));
        check("a0 latency", 64'(cyc - e.cap), 64'd8);
        if (sweep_on && last_a0 != 0) check("a0 period", 64'(cyc - last_a0), 64'd9);
        last_a0 = cyc;
      end
    end
  end

  always @(negedge clk) begin : mon_a1
    exp_t e;
    if (!rst && done_a1) begin
      if (q1.size() == 0) unexpected("a1 extra DONE");
      else begin
        e = q1.pop_front();
        check("a1 bcd", 64'(bcd_a1), 64'(e.bcd));
        check("a1 ovf", 64'(ovf_a1), 64'(e.ovf));
        check("a1 latency", 64'(cyc - e.cap), 64'd8);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!rst && done_b) begin
      if (q2.size() == 0) unexpected("b extra DONE");
      else begin
        e = q2.pop_front();
        check("b bcd", 64'(bcd_b), 64'(e.bcd));
        check("b ovf", 64'(ovf_b), 64'(e.ovf));
        check("b latency", 64'(cyc - e.cap), 64'd18);
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  // Called at a negedge. dec_bcd is the decimal digits of n when in range.
  task automatic issue_a(input logic [6:0] n, input logic [7:0] dec_bcd,
                         input logic ovf, input bit push);
    exp_t e;
    start_a = 1'b1;
    num_a   = n;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    num_a   = ~n;            // later NUMBER changes must not matter
    if (push) begin
      e.cap = cyc;
      e.ovf = ovf;
      e.bcd = ovf ? 20'h00 : 20'(dec_bcd);
      q0.push_back(e);
      e.bcd = ovf ? 20'h99 : 20'(dec_bcd);
      q1.push_back(e);
    end
  endtask

  task automatic issue_b(input logic [16:0] n, input logic [19:0] dec_bcd, input logic ovf);
    exp_t e;
    start_b = 1'b1;
    num_b   = n;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    num_b   = ~n;
    e.cap = cyc;
    e.ovf = ovf;
    e.bcd = ovf ? 20'h0 : dec_bcd;
    q2.push_back(e);
  endtask

  // Returns at the negedge where DONE is seen, counting BUSY cycles before it.
  task automatic wait_done_a(input string name, output int busy_cnt);
    bit seen;
    seen = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done_a0) seen = 1'b1;
      else if (busy_a0) busy_cnt++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: DONE timeout", name);
    end
  endtask

  task automatic wait_done_b(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done_b) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: DONE timeout", name);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int bc;
    logic [7:0] dec;

    #2 rst = 1'b1;
    #3;
    check("reset a0 bcd",  64'(bcd_a0),  64'h0);
    check("reset a0 busy", 64'(busy_a0), 64'h0);
    check("reset a0 done", 64'(done_a0), 64'h0);
    check("reset a0 ovf",  64'(ovf_a0),  64'h0);
    check("reset b bcd",   64'(bcd_b),   64'h0);
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(1);

    // Single conversion, BUSY width.
    issue_a(7'd59, 8'h59, 1'b0, 1'b1);
    wait_done_a("59", bc);
    check("59 busy cycles", 64'(bc), 64'd8);
    idle_cycles(2);

    // Back-to-back sweep, START in each DONE cycle.
    sweep_on = 1'b1;
    last_a0  = 0;
    issue_a(7'd0, 8'h00, 1'b0, 1'b1);
    for (int n = 1; n < 100; n++) begin
      wait_done_a("sweep", bc);
      dec = {4'(n / 10), 4'(n % 10)};
      issue_a(7'(n), dec, 1'b0, 1'b1);
    end
    wait_done_a("sweep last", bc);
    sweep_on = 1'b0;
    idle_cycles(2);

    // START during a conversion is ignored.
    issue_a(7'd42, 8'h42, 1'b0, 1'b1);
    idle_cycles(3);
    start_a = 1'b1;
    num_a   = 7'd12;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a("ignore", bc);
    idle_cycles(12);
    check("ignore single DONE", 64'(q0.size()), 64'd0);

    // Out-of-range inputs.
    issue_a(7'd127, 8'h00, 1'b1, 1'b1);
    wait_done_a("127", bc);
    idle_cycles(1);
    issue_a(7'd100, 8'h00, 1'b1, 1'b1);
    wait_done_a("100", bc);
    idle_cycles(3);
    check("hold a1 bcd", 64'(bcd_a1), 64'h99);
    check("hold a1 ovf", 64'(ovf_a1), 64'h1);

    // Reset mid-SHIFT aborts without a DONE.
    issue_a(7'd99, 8'h99, 1'b0, 1'b0);
    idle_cycles(3);
    #2 rst = 1'b1;
    #1;
    check("abort a0 busy", 64'(busy_a0), 64'h0);
    check("abort a0 done", 64'(done_a0), 64'h0);
    check("abort a0 ovf",  64'(ovf_a0),  64'h0);
    check("abort a1 busy", 64'(busy_a1), 64'h0);
    check("abort a1 bcd",  64'(bcd_a1),  64'h0);
    check("abort a1 ovf",  64'(ovf_a1),  64'h0);
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(12);
    issue_a(7'd7, 8'h07, 1'b0, 1'b1);
    wait_done_a("7 after reset", bc);
    idle_cycles(2);

    // Wide instance.
    issue_b(17'd86399, 20'h86399, 1'b0);
    wait_done_b("86399");
    idle_cycles(1);
    issue_b(17'd100000, 20'h0, 1'b1);
    wait_done_b("100000");
    issue_b(17'd99999, 20'h99999, 1'b0);
    wait_done_b("99999");
    issue_b(17'd0, 20'h0, 1'b0);
    wait_done_b("0");
    idle_cycles(4);

    check("a0 queue drained", 64'(q0.size()), 64'd0);
    check("a1 queue drained", 64'(q1.size()), 64'd0);
    check("b queue drained",  64'(q2.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
